// File: rtl/ahb_stream_loader_if.sv
// Byte-stream input and AHB-Lite master bus of the stream loader.
// The master modport is the loader's view; slave is the stream source plus RAM side.
interface ahb_stream_loader_if #(
  parameter int unsigned AW = 16
);
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_last;
  logic          s_ready;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HRESP;

  modport master (
    input  s_valid, s_data, s_last, HREADY, HRESP,
    output s_ready, HADDR, HTRANS, HSIZE, HWRITE, HWDATA
  );

  modport slave (
    output s_valid, s_data, s_last, HREADY, HRESP,
    input  s_ready, HADDR, HTRANS, HSIZE, HWRITE, HWDATA
  );
endinterface

// File: rtl/ahb_stream_loader.sv
// AHB-Lite single master: packs a byte stream little-endian into 32-bit words
// and writes them to consecutive word addresses.
module ahb_stream_loader #(
  parameter int unsigned AW = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 start,
  input  logic [AW-1:0]        start_addr,
  ahb_stream_loader_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [AW-1:0]        word_count
);

  localparam int unsigned DW = 32;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_ADDR    = 2'd2,
    S_DATA    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic [DW-1:0] word_q, word_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] hwdata_q, hwdata_d;
  logic [1:0]    htrans_q, htrans_d;
  logic          hwrite_q, hwrite_d;
  logic          s_ready_q, s_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [AW-1:0] count_q, count_d;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      lane_q    <= '0;
      word_q    <= '0;
      last_q    <= 1'b0;
      addr_q    <= '0;
      hwdata_q  <= '0;
      htrans_q  <= HTRANS_IDLE;
      hwrite_q  <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      word_q    <= word_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      hwdata_q  <= hwdata_d;
      htrans_q  <= htrans_d;
      hwrite_q  <= hwrite_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      count_q   <= count_d;
    end
  end

  // Next state; bus-facing outputs are decoded from the next state so they are registered.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    word_d   = word_q;
    last_d   = last_q;
    addr_d   = addr_q;
    hwdata_d = hwdata_q;
    done_d   = 1'b0;
    error_d  = error_q;
    count_d  = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          addr_d  = start_addr & ~AW'(3);
          lane_d  = '0;
          last_d  = 1'b0;
          error_d = 1'b0;
          count_d = '0;
        end
      end
      S_COLLECT: begin
        if (bus.s_valid) begin
          // Lane 0 clears the word so a short final word has zero upper bytes.
          if (lane_q == 2'd0) word_d = DW'(bus.s_data);
          else                word_d[{lane_q, 3'b000} +: 8] = bus.s_data;
          last_d = bus.s_last;
          lane_d = lane_q + 2'd1;
          if (bus.s_last || lane_q == 2'd3) begin
            state_d = S_ADDR;
            lane_d  = '0;
          end
        end
      end
      S_ADDR: begin
        if (bus.HREADY) begin
          state_d  = S_DATA;
          hwdata_d = word_q;
        end
      end
      S_DATA: begin
        if (bus.HRESP) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else if (bus.HREADY) begin
          addr_d  = addr_q + AW'(4);
          count_d = count_q + AW'(1);
          if (last_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    s_ready_d = (state_d == S_COLLECT);
    htrans_d  = (state_d == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    hwrite_d  = (state_d == S_ADDR);
    busy_d    = (state_d != S_IDLE);
  end

  assign bus.s_ready = s_ready_q;
  assign bus.HADDR   = addr_q;
  assign bus.HTRANS  = htrans_q;
  assign bus.HSIZE   = 3'b010;
  assign bus.HWRITE  = hwrite_q;
  assign bus.HWDATA  = hwdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign word_count  = count_q;

endmodule

// File: tb/tb_ahb_stream_loader.sv
// Directed self-checking bench for ahb_stream_loader with a passive AHB write recorder.
module tb_ahb_stream_loader;

  localparam int unsigned AW = 16;

  logic          HCLK;
  logic          HRESET;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          busy, done, error;
  logic [AW-1:0] word_count;

  ahb_stream_loader_if #(.AW(AW)) bus ();

  ahb_stream_loader #(.AW(AW)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .start      (start),
    .start_addr (start_addr),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  int checks   = 0;
  int failures = 0;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Records completed AHB writes as seen by a slave.
  logic [AW-1:0] wa [$];
  logic [31:0]   wd [$];
  logic          dph;
  logic [AW-1:0] dph_addr;
  int            done_cnt = 0;

  always @(posedge HCLK) begin
    if (HRESET) begin
      dph <= 1'b0;
    end else if (bus.HREADY) begin
      if (dph && !bus.HRESP) begin
        wa.push_back(dph_addr);
        wd.push_back(bus.HWDATA);
      end
      dph      <= (bus.HTRANS == 2'b10);
      dph_addr <= bus.HADDR;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge HCLK);
  endtask

  task automatic do_start(input logic [AW-1:0] a);
    start      = 1'b1;
    start_addr = a;
    tick();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l);
    int n;
    n = 0;
    while (bus.s_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("s_ready_timeout", 32'(bus.s_ready), 32'd1);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    bus.s_last  = l;
    tick();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [AW-1:0] a, input logic [31:0] d);
    if (idx < wa.size()) begin
      chk({tag, "_addr"}, 32'(wa[idx]), 32'(a));
      chk({tag, "_data"}, wd[idx], d);
    end else begin
      chk({tag, "_count"}, 32'(wa.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int dc;
    HRESET      = 1'b1;
    start       = 1'b0;
    start_addr  = '0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.HREADY  = 1'b1;
    bus.HRESP   = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_htrans",  32'(bus.HTRANS), 32'd0);
    chk("rst_hwrite",  32'(bus.HWRITE), 32'd0);
    chk("rst_haddr",   32'(bus.HADDR), 32'd0);
    chk("rst_hwdata",  bus.HWDATA, 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    chk("rst_error",   32'(error), 32'd0);
    chk("rst_count",   32'(word_count), 32'd0);
    chk("hsize",       32'(bus.HSIZE), 32'd2);
    HRESET = 1'b0;
    tick();

    // Bytes offered while idle must not be taken
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hEE;
    repeat (2) tick();
    chk("idle_s_ready", 32'(bus.s_ready), 32'd0);
    bus.s_valid = 1'b0;

    // Test 1: single word, zero wait states, latency
    wa.delete(); wd.delete();
    do_start(16'h0100);
    chk("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    chk("t1_nonseq",  32'(bus.HTRANS), 32'd2);
    chk("t1_hwrite",  32'(bus.HWRITE), 32'd1);
    chk("t1_haddr",   32'(bus.HADDR), 32'h0100);
    chk("t1_sready0", 32'(bus.s_ready), 32'd0);
    tick();
    chk("t1_dph_htrans", 32'(bus.HTRANS), 32'd0);
    chk("t1_dph_hwrite", 32'(bus.HWRITE), 32'd0);
    chk("t1_hwdata",     bus.HWDATA, 32'h44332211);
    tick();
    chk("t1_done",  32'(done), 32'd1);
    chk("t1_busy0", 32'(busy), 32'd0);
    chk("t1_count", 32'(word_count), 32'd1);
    chk("t1_nwr",   32'(wa.size()), 32'd1);
    chk_wr("t1_w0", 0, 16'h0100, 32'h44332211);
    tick();
    chk("t1_done_pulse", 32'(done), 32'd0);

    // Test 2: nine bytes, partial last word
    wa.delete(); wd.delete();
    do_start(16'h0200);
    for (int i = 1; i <= 9; i++) send_byte(8'(i), (i == 9));
    wait_done("t2_done");
    chk("t2_count", 32'(word_count), 32'd3);
    chk("t2_nwr",   32'(wa.size()), 32'd3);
    chk_wr("t2_w0", 0, 16'h0200, 32'h04030201);
    chk_wr("t2_w1", 1, 16'h0204, 32'h08070605);
    chk_wr("t2_w2", 2, 16'h0208, 32'h00000009);
    tick();

    // Test 3: three wait states in each phase
    wa.delete(); wd.delete();
    do_start(16'h0300);
    bus.HREADY = 1'b0;
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    send_byte(8'hA4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_a_htrans", 32'(bus.HTRANS), 32'd2);
      chk("t3_a_haddr",  32'(bus.HADDR), 32'h0300);
      chk("t3_a_sready", 32'(bus.s_ready), 32'd0);
      tick();
    end
    bus.HREADY = 1'b1;
    tick();
    bus.HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_d_htrans", 32'(bus.HTRANS), 32'd0);
      chk("t3_d_hwdata", bus.HWDATA, 32'hA4A3A2A1);
      chk("t3_d_sready", 32'(bus.s_ready), 32'd0);
      tick();
    end
    chk("t3_nwr_wait", 32'(wa.size()), 32'd0);
    bus.HREADY = 1'b1;
    wait_done("t3_done");
    chk("t3_nwr", 32'(wa.size()), 32'd1);
    chk_wr("t3_w0", 0, 16'h0300, 32'hA4A3A2A1);
    tick();

    // Test 4: address wrap, low address bits ignored
    wa.delete(); wd.delete();
    do_start(16'hFFFE);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), (i == 7));
    wait_done("t4_done");
    chk_wr("t4_w0", 0, 16'hFFFC, 32'h13121110);
    chk_wr("t4_w1", 1, 16'h0000, 32'h17161514);
    tick();

    // Test 5: error response on second word, then restart clears error
    wa.delete(); wd.delete();
    dc = done_cnt;
    do_start(16'h0400);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h20 + i), 1'b0);
    tick();
    chk("t5_dph_hwdata", bus.HWDATA, 32'h27262524);
    bus.HREADY = 1'b0;
    bus.HRESP  = 1'b1;
    tick();
    chk("t5_error",  32'(error), 32'd1);
    chk("t5_busy",   32'(busy), 32'd0);
    chk("t5_htrans", 32'(bus.HTRANS), 32'd0);
    chk("t5_done",   32'(done), 32'd0);
    bus.HREADY = 1'b1;
    tick();
    bus.HRESP = 1'b0;
    repeat (3) tick();
    chk("t5_error_sticky", 32'(error), 32'd1);
    chk("t5_no_done", 32'(done_cnt - dc), 32'd0);
    chk("t5_nwr",     32'(wa.size()), 32'd1);
    chk("t5_count",   32'(word_count), 32'd1);
    do_start(16'h0500);
    chk("t5_err_clr",   32'(error), 32'd0);
    chk("t5_count_clr", 32'(word_count), 32'd0);

    // Test 6: start while busy ignored, reset during address wait
    send_byte(8'h31, 1'b0);
    do_start(16'h0800);
    bus.HREADY = 1'b0;
    send_byte(8'h32, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h34, 1'b0);
    chk("t6_htrans", 32'(bus.HTRANS), 32'd2);
    chk("t6_haddr",  32'(bus.HADDR), 32'h0500);
    tick();
    HRESET = 1'b1;
    tick();
    chk("t6_rst_htrans", 32'(bus.HTRANS), 32'd0);
    chk("t6_rst_hwrite", 32'(bus.HWRITE), 32'd0);
    chk("t6_rst_haddr",  32'(bus.HADDR), 32'd0);
    chk("t6_rst_hwdata", bus.HWDATA, 32'd0);
    chk("t6_rst_busy",   32'(busy), 32'd0);
    chk("t6_rst_sready", 32'(bus.s_ready), 32'd0);
    HRESET     = 1'b0;
    bus.HREADY = 1'b1;
    repeat (2) tick();
    chk("t6_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
